pin_probe: RTL and testbench

Parametrised board bring-up block for pin-continuity testing on the HWIC-3G board.
- Captures activity on an arbitrary number of FPGA input pins through synchronisers and edge detectors, with per-pin sticky "seen" flags and a live seen count.
- Scans the flags one pin at a time onto an LED.
- Drives the output pin bank with a selectable stimulus pattern, either all pins toggling together or a walking one.
- Sits directly under the board top level, between raw package pins and the LEDs.

---
 rtl/pin_probe_pkg.sv | 13 +
 rtl/pin_probe_sync_edge.sv | 30 +++
 rtl/pin_probe.sv | 171 +++++++++++++++++
 tb/tb_pin_probe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pin_probe_pkg.sv
// pin_probe shared types: output pattern mode enum
// and default prescaler / synchroniser constants.
package pin_probe_pkg;

  typedef enum logic {
    PAT_TOGGLE = 1'b0,
    PAT_WALK   = 1'b1
  } pat_e;

  localparam int TICK_LOG2_DEF   = 22;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pin_probe_sync_edge.sv
// One monitored pin: SYNC_STAGES-deep synchroniser, prev flop, armed edge.
// Ports: clk25, rst_, pin (async), armed, pulse (edge, gated by armed).
module pin_probe_sync_edge
  import pin_probe_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk25,
  input  logic rst_,
  input  logic pin,
  input  logic armed,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/pin_probe.sv
// pin_probe: pin continuity probe - sticky per-pin activity flags scanned
// onto leds[3], heartbeat on leds[2:0], stimulus pattern on pins_out.
// Ports: clk25, rst_ (async low), pins_in, mode, clr_sticky,
//        leds, pins_out, sel_idx, seen_cnt, activity.
// Build option PIN_PROBE_WALK_EN enables the walking-one pattern (mode=1).
module pin_probe
  import pin_probe_pkg::*;
#(
  parameter int N_IN        = 64,
  parameter int N_OUT       = 163,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TICK_LOG2   = TICK_LOG2_DEF,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CNT_W = $clog2(N_IN + 1)
) (
  input  logic             clk25,
  input  logic             rst_,
  input  logic [N_IN-1:0]  pins_in,
  input  logic             mode,
  input  logic             clr_sticky,
  output logic [3:0]       leds,
  output logic [N_OUT-1:0] pins_out,
  output logic [SEL_W-1:0] sel_idx,
  output logic [CNT_W-1:0] seen_cnt,
  output logic             activity
);

  localparam int CW = TICK_LOG2 + 3;

  logic [CW-1:0]   cntr;
  logic            tick;
  logic [2:0]      arm_cnt;
  logic            armed;
  logic [N_IN-1:0] edges;
  logic [N_IN-1:0] seen_q;
  logic [CNT_W-1:0] cnt_d;
  logic            scan_led;

  assign tick  = &cntr[TICK_LOG2-1:0];
  assign armed = (arm_cnt == 3'(SYNC_STAGES + 1));
  assign leds  = {scan_led, cntr[CW-1 -: 3]};

  // Arming counter holds off edges until the synchroniser
  // and prev flops have filled with real pin levels.
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      cntr    <= '0;
      arm_cnt <= '0;
    end else begin
      cntr <= cntr + 1'b1;
      if (!armed)
        arm_cnt <= arm_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_pin
    pin_probe_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk25(clk25),
      .rst_ (rst_),
      .pin  (pins_in[g]),
      .armed(armed),
      .pulse(edges[g])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_IN; i++)
      cnt_d = cnt_d + CNT_W'(seen_q[i]);
  end

  // Edge wins over clear in the same cycle.
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      seen_q   <= '0;
      seen_cnt <= '0;
      activity <= 1'b0;
      scan_led <= 1'b0;
      sel_idx  <= '0;
    end else begin
      seen_q   <= (seen_q & ~{N_IN{clr_sticky}}) | edges;
      seen_cnt <= cnt_d;
      activity <= |seen_q;
      scan_led <= seen_q[sel_idx];
      if (tick) begin
        if (sel_idx == SEL_W'(N_IN - 1))
          sel_idx <= '0;
        else
          sel_idx <= sel_idx + 1'b1;
      end
    end
  end

  logic             tog_q;
  logic             tog_d;
  logic [N_OUT-1:0] out_d;

`ifdef PIN_PROBE_WALK_EN
  localparam int WALK_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  pat_e              mode_q;
  pat_e              mode_d;
  logic [WALK_W-1:0] walk_q;
  logic [WALK_W-1:0] walk_d;

  always_comb begin
    tog_d  = tog_q;
    mode_d = mode_q;
    walk_d = walk_q;
    out_d  = pins_out;
    if (tick) begin
      tog_d  = ~tog_q;
      mode_d = pat_e'(mode);
      unique case (mode_d)
        PAT_WALK: begin
          // Entering walk mode restarts at bit 0.
          if (mode_q == PAT_TOGGLE)
            walk_d = '0;
          else if (walk_q == WALK_W'(N_OUT - 1))
            walk_d = '0;
          else
            walk_d = walk_q + 1'b1;
          out_d = '0;
          out_d[walk_d] = 1'b1;
        end
        PAT_TOGGLE: out_d = {N_OUT{tog_d}};
        default:    out_d = {N_OUT{tog_d}};
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      tog_q    <= 1'b0;
      mode_q   <= PAT_TOGGLE;
      walk_q   <= '0;
      pins_out <= '0;
    end else begin
      tog_q    <= tog_d;
      mode_q   <= mode_d;
      walk_q   <= walk_d;
      pins_out <= out_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    tog_d = tog_q;
    out_d = pins_out;
    if (tick) begin
      tog_d = ~tog_q;
      out_d = {N_OUT{tog_d}};
    end
  end

  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      tog_q    <= 1'b0;
      pins_out <= '0;
    end else begin
      tog_q    <= tog_d;
      pins_out <= out_d;
    end
  end
`endif

endmodule

// File: tb/tb_pin_probe.sv
// tb_pin_probe: scoreboard bench for pin_probe (N_IN=8, N_OUT=5,
// SYNC_STAGES=2, TICK_LOG2=3); follows PIN_PROBE_WALK_EN like the RTL.
module tb_pin_probe;

  logic       clk25;
  logic       rst_;
  logic [7:0] pins_in;
  logic       mode;
  logic       clr_sticky;
  logic [3:0] leds;
  logic [4:0] pins_out;
  logic [2:0] sel_idx;
  logic [3:0] seen_cnt;
  logic       activity;

  pin_probe #(
    .N_IN(8),
    .N_OUT(5),
    .SYNC_STAGES(2),
    .TICK_LOG2(3)
  ) dut (
    .clk25     (clk25),
    .rst_      (rst_),
    .pins_in   (pins_in),
    .mode      (mode),
    .clr_sticky(clr_sticky),
    .leds      (leds),
    .pins_out  (pins_out),
    .sel_idx   (sel_idx),
    .seen_cnt  (seen_cnt),
    .activity  (activity)
  );

  localparam int S_OUT = 0;
  localparam int S_SEL = 1;
  localparam int S_CNT = 2;
  localparam int S_ACT = 3;
  localparam int S_L3  = 4;
  localparam int S_HB  = 5;
  localparam int S_LED = 6;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   cyc;

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  always @(posedge clk25 or negedge rst_) begin
    if (!rst_) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_OUT:   return 32'(pins_out);
      S_SEL:   return 32'(sel_idx);
      S_CNT:   return 32'(seen_cnt);
      S_ACT:   return 32'(activity);
      S_L3:    return 32'(leds[3]);
      S_HB:    return 32'(leds[2:0]);
      default: return 32'(leds);
    endcase
  endfunction

  task automatic push(int at, int sig, logic [31:0] v, string tag);
    exp_t e;
    e.at  = at;
    e.sig = sig;
    e.exp = v;
    e.tag = $sformatf("%s@%0d", tag, at);
    sb.push_back(e);
  endtask

  task automatic drain(int at);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == at) begin
        check(sb[i].tag, sample(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  always @(posedge clk25) begin
    #1;
    if (rst_) drain(cyc);
  end

  function automatic logic [31:0] tog_exp(int k);
    return ((k / 8) % 2 == 1) ? 32'h1F : 32'h0;
  endfunction

  function automatic logic [31:0] walk_exp(int k);
`ifdef PIN_PROBE_WALK_EN
    if (k < 8) return 32'h0;
    return 32'h1 << (((k / 8) - 1) % 5);
`else
    return tog_exp(k);
`endif
  endfunction

  task automatic at_cyc(int c);
    int n;
    n = 0;
    @(negedge clk25);
    while (cyc < c && n < 2000) begin
      @(negedge clk25);
      n++;
    end
    if (cyc != c) check("at_cyc", 32'(cyc), 32'(c));
  endtask

  task automatic reset_checks(string tag);
    push(-1, S_OUT, 0, {tag, "_out"});
    push(-1, S_SEL, 0, {tag, "_sel"});
    push(-1, S_CNT, 0, {tag, "_cnt"});
    push(-1, S_ACT, 0, {tag, "_act"});
    push(-1, S_LED, 0, {tag, "_leds"});
    drain(-1);
  endtask

  task automatic do_reset();
    @(negedge clk25);
    rst_ = 1'b0;
    #1;
    reset_checks("rst");
    repeat (3) @(negedge clk25);
    rst_ = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_       = 1'b0;
    pins_in    = 8'hFF;
    mode       = 1'b0;
    clr_sticky = 1'b0;
    repeat (3) @(negedge clk25);
    reset_checks("por");

    // Pins high through reset: no false seen; toggle pattern and scan.
    for (int k = 1; k <= 100; k++) begin
      push(k, S_CNT, 0, "p1_cnt");
      push(k, S_ACT, 0, "p1_act");
      push(k, S_L3, 0, "p1_l3");
      push(k, S_OUT, tog_exp(k), "p1_out");
      push(k, S_SEL, (k / 8) % 8, "p1_sel");
      push(k, S_HB, (k / 8) % 8, "p1_hb");
    end
    rst_ = 1'b1;
    at_cyc(101);

    // Single edge latency, then edge-beats-clear.
    pins_in = 8'h00;
    do_reset();
    push(23, S_CNT, 0, "p2_cnt");
    push(23, S_ACT, 0, "p2_act");
    push(24, S_CNT, 1, "p2_cnt");
    push(24, S_ACT, 1, "p2_act");
    push(24, S_L3, 0, "p2_l3");
    for (int k = 25; k <= 32; k++) push(k, S_L3, 1, "p2_l3");
    push(33, S_L3, 0, "p2_l3");
    push(44, S_CNT, 4, "p3_cnt");
    push(53, S_CNT, 4, "p3_cnt");
    push(54, S_CNT, 1, "p3_cnt");
    push(54, S_ACT, 1, "p3_act");
    push(60, S_CNT, 1, "p3_cnt");
    push(90, S_L3, 0, "p3_l3");
    push(98, S_L3, 0, "p3_l3");
    push(106, S_L3, 1, "p3_l3");
    at_cyc(20);
    pins_in[3] = 1'b1;
    at_cyc(40);
    pins_in[2:0] = 3'b111;
    at_cyc(50);
    pins_in[5] = 1'b1;
    at_cyc(52);
    clr_sticky = 1'b1;
    at_cyc(53);
    clr_sticky = 1'b0;
    at_cyc(110);

    // Walking one, mid-walk reset, restart, mode switches.
    pins_in = 8'h00;
    mode    = 1'b1;
    do_reset();
    for (int k = 1; k <= 75; k++) push(k, S_OUT, walk_exp(k), "p4_out");
    at_cyc(75);
    rst_ = 1'b0;
    #1;
    reset_checks("mid");
    repeat (3) @(negedge clk25);
    rst_ = 1'b1;
    for (int k = 1; k <= 23; k++) push(k, S_OUT, walk_exp(k), "p5_out");
    for (int k = 24; k <= 31; k++) push(k, S_OUT, 32'h1F, "p5_out");
`ifdef PIN_PROBE_WALK_EN
    for (int k = 32; k <= 39; k++) push(k, S_OUT, 32'h01, "p5_out");
    push(40, S_OUT, 32'h02, "p5_out");
`else
    for (int k = 32; k <= 40; k++) push(k, S_OUT, tog_exp(k), "p5_out");
`endif
    at_cyc(20);
    mode = 1'b0;
    at_cyc(28);
    mode = 1'b1;
    at_cyc(41);

    check("sb_left", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
